// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: bundles the FIFO client side and the single-port RAM side
// of fifo_ctrl into one interface with master (client/RAM) and slave (controller) views.
interface fifo_ctrl_if #(
    parameter int AW = 3,
    parameter int DW = 4
);
    logic          push;
    logic          pop;
    logic [DW-1:0] data_in;
    logic [AW:0]   almost_full_th;
    logic [AW:0]   almost_empty_th;
    logic [DW-1:0] ram_data_out;
    logic [AW-1:0] ram_addr;
    logic          ram_rw;
    logic [DW-1:0] ram_data_in;
    logic          ram_reset_n;
    logic          push_ready;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow_err;
    logic          underflow_err;

    modport master (
        output push, pop, data_in, almost_full_th, almost_empty_th,
        output ram_data_out,
        input  ram_addr, ram_rw, ram_data_in, ram_reset_n,
        input  push_ready, data_out, data_valid, count,
        input  full, empty, almost_full, almost_empty,
        input  overflow_err, underflow_err
    );

    modport slave (
        input  push, pop, data_in, almost_full_th, almost_empty_th,
        input  ram_data_out,
        output ram_addr, ram_rw, ram_data_in, ram_reset_n,
        output push_ready, data_out, data_valid, count,
        output full, empty, almost_full, almost_empty,
        output overflow_err, underflow_err
    );
endinterface

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: single-clock FIFO controller driving a single-port RAM.
// Optional sticky error flags are built when FIFO_CTRL_ERR_EN is defined.
module fifo_ctrl #(
    parameter int AW = 3,
    parameter int DW = 4
) (
    input  logic        clk,
    input  logic        reset,
    fifo_ctrl_if.slave  bus
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_run;
    logic          w_ram_reset_n;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [DW-1:0] r_data_out;
    logic          r_data_valid;

    logic          w_full;
    logic          w_empty;
    logic          w_pop_acc;
    logic          w_push_acc;

    // State register: reset always lands in INIT
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // INIT holds the RAM in clear for one cycle, then RUN forever
    always_comb begin
        w_state_nxt   = r_state;
        w_run         = 1'b0;
        w_ram_reset_n = 1'b0;
        unique case (r_state)
            INIT: begin
                w_state_nxt = RUN;
            end
            RUN: begin
                w_run         = !reset;
                w_ram_reset_n = !reset;
            end
            default: begin
                w_state_nxt = INIT;
            end
        endcase
    end

    assign w_full     = (r_count == DEPTH);
    assign w_empty    = (r_count == '0);
    assign w_pop_acc  = w_run && bus.pop && !w_empty;
    assign w_push_acc = w_run && bus.push && !w_full && !w_pop_acc;

    // Pointer and occupancy bookkeeping; pointers wrap by overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_count  <= r_count + 1'b1;
            end else if (w_pop_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count  <= r_count - 1'b1;
            end
        end
    end

    // Capture the RAM word on each accepted pop; valid pulses one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= w_pop_acc;
            if (w_pop_acc) begin
                r_data_out <= bus.ram_data_out;
            end
        end
    end

`ifdef FIFO_CTRL_ERR_EN
    logic r_overflow_err;
    logic r_underflow_err;

    // Sticky misuse flags, only meaningful while running
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow_err  <= 1'b0;
            r_underflow_err <= 1'b0;
        end else begin
            if (w_run && bus.push && w_full) begin
                r_overflow_err <= 1'b1;
            end
            if (w_run && bus.pop && w_empty) begin
                r_underflow_err <= 1'b1;
            end
        end
    end

    assign bus.overflow_err  = r_overflow_err;
    assign bus.underflow_err = r_underflow_err;
`else
    assign bus.overflow_err  = 1'b0;
    assign bus.underflow_err = 1'b0;
`endif

    // Pop owns the single RAM port whenever it is accepted
    assign bus.ram_addr     = w_pop_acc ? r_rd_ptr : r_wr_ptr;
    assign bus.ram_rw       = w_push_acc;
    assign bus.ram_data_in  = bus.data_in;
    assign bus.ram_reset_n  = w_ram_reset_n;

    assign bus.push_ready   = w_run && !w_full && !(bus.pop && !w_empty);
    assign bus.data_out     = r_data_out;
    assign bus.data_valid   = r_data_valid;
    assign bus.count        = r_count;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= bus.almost_full_th);
    assign bus.almost_empty = (r_count <= bus.almost_empty_th);

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: randomized and directed checks of fifo_ctrl against a
// queue-based FIFO model, with a behavioural RAM attached.
module tb_fifo_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fifo_ctrl_if #(.AW(3), .DW(4)) bus ();

    fifo_ctrl #(.AW(3), .DW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [3:0] mem [8];
    always @(posedge clk) begin
        if (!bus.ram_reset_n) begin
            for (int i = 0; i < 8; i++) mem[i] <= 4'h0;
        end else if (bus.ram_rw) begin
            mem[bus.ram_addr] <= bus.ram_data_in;
        end
    end
    assign bus.ram_data_out = mem[bus.ram_addr];

`ifdef FIFO_CTRL_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    int chk = 0;
    int err = 0;

    logic [3:0] q[$];
    bit         m_run = 0;
    logic [3:0] m_dout = 0;
    bit         m_dv = 0;
    bit         m_ovf = 0;
    bit         m_udf = 0;

    logic obs_pr, obs_rrn, obs_rw;
    bit   exp_pr, exp_rrn, exp_rw;

    // One clock of stimulus: sample combinational outputs mid-cycle, then
    // advance the model at the edge and settle just after it.
    task automatic step(input bit rst, input bit ps, input bit pp,
                        input logic [3:0] din);
        bit pa, wa;
        @(negedge clk);
        reset = rst;
        bus.push = ps;
        bus.pop = pp;
        bus.data_in = din;
        #1;
        obs_pr  = bus.push_ready;
        obs_rrn = bus.ram_reset_n;
        obs_rw  = bus.ram_rw;
        pa = m_run && !rst && pp && q.size() > 0;
        wa = m_run && !rst && ps && q.size() < 8 && !pa;
        exp_pr  = m_run && !rst && q.size() < 8 && !(pp && q.size() > 0);
        exp_rrn = m_run && !rst;
        exp_rw  = wa;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_run = 0; m_dout = 0; m_dv = 0; m_ovf = 0; m_udf = 0;
        end else begin
            if (m_run && ps && q.size() == 8) m_ovf = 1;
            if (m_run && pp && q.size() == 0) m_udf = 1;
            m_dv = pa;
            if (pa) m_dout = q.pop_front();
            if (wa) q.push_back(din);
            m_run = 1;
        end
        #1;
    endtask

    task automatic do_reset();
        repeat (3) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
    endtask

    task automatic test_reset();
        bus.almost_full_th = 4'd5;
        bus.almost_empty_th = 4'd0;
        repeat (3) step(1, 0, 0, 0);
        chk++; if (bus.count !== 4'd0) begin err++; $display("FAIL rst_count got %0d exp 0", bus.count); end
        chk++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin err++; $display("FAIL rst_flags got e=%b f=%b exp e=1 f=0", bus.empty, bus.full); end
        chk++; if (bus.data_valid !== 1'b0 || bus.data_out !== 4'h0) begin err++; $display("FAIL rst_data got v=%b d=%h exp 0 0", bus.data_valid, bus.data_out); end
        chk++; if (obs_pr !== 1'b0 || obs_rrn !== 1'b0 || obs_rw !== 1'b0) begin err++; $display("FAIL rst_comb got pr=%b rrn=%b rw=%b exp 0 0 0", obs_pr, obs_rrn, obs_rw); end
        chk++; if (bus.ram_addr !== 3'd0) begin err++; $display("FAIL rst_addr got %0d exp 0", bus.ram_addr); end
        chk++; if (bus.almost_empty !== 1'b1 || bus.almost_full !== 1'b0) begin err++; $display("FAIL rst_almost got ae=%b af=%b exp 1 0", bus.almost_empty, bus.almost_full); end
        chk++; if (bus.overflow_err !== 1'b0 || bus.underflow_err !== 1'b0) begin err++; $display("FAIL rst_errs got %b%b exp 00", bus.overflow_err, bus.underflow_err); end
        bus.almost_full_th = 4'd0;
        #1;
        chk++; if (bus.almost_full !== 1'b1) begin err++; $display("FAIL rst_af_th0 got %b exp 1", bus.almost_full); end
        bus.almost_full_th = 4'd6;
        step(0, 1, 0, 4'h5);
        chk++; if (obs_rrn !== 1'b0 || obs_pr !== 1'b0) begin err++; $display("FAIL init_cycle got rrn=%b pr=%b exp 0 0", obs_rrn, obs_pr); end
        chk++; if (bus.count !== 4'd0) begin err++; $display("FAIL init_push_ignored got %0d exp 0", bus.count); end
        step(0, 0, 0, 0);
        chk++; if (obs_rrn !== 1'b1 || obs_pr !== 1'b1) begin err++; $display("FAIL run_entry got rrn=%b pr=%b exp 1 1", obs_rrn, obs_pr); end
        chk++; if (bus.empty !== 1'b1 || bus.count !== 4'd0) begin err++; $display("FAIL run_empty got e=%b c=%0d exp 1 0", bus.empty, bus.count); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 0, 4'(i));
            chk++; if (bus.count !== 4'(i)) begin err++; $display("FAIL fill_count got %0d exp %0d", bus.count, i); end
        end
        chk++; if (bus.full !== 1'b1 || bus.push_ready !== 1'b0) begin err++; $display("FAIL fill_full got f=%b pr=%b exp 1 0", bus.full, bus.push_ready); end
        step(0, 1, 0, 4'h9);
        chk++; if (bus.count !== 4'd8 || obs_pr !== 1'b0) begin err++; $display("FAIL over_count got c=%0d pr=%b exp 8 0", bus.count, obs_pr); end
        chk++; if (bus.overflow_err !== ERR_EN) begin err++; $display("FAIL overflow_err got %b exp %b", bus.overflow_err, ERR_EN); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 0);
            chk++; if (bus.data_valid !== 1'b1 || bus.data_out !== 4'(i + 1)) begin err++; $display("FAIL drain_data got v=%b d=%h exp 1 %h", bus.data_valid, bus.data_out, 4'(i + 1)); end
        end
        chk++; if (bus.empty !== 1'b1 || bus.count !== 4'd0) begin err++; $display("FAIL drain_empty got e=%b c=%0d exp 1 0", bus.empty, bus.count); end
        step(0, 0, 0, 0);
        chk++; if (bus.data_valid !== 1'b0) begin err++; $display("FAIL dv_pulse got %b exp 0", bus.data_valid); end
        step(0, 0, 1, 0);
        chk++; if (bus.data_valid !== 1'b0 || bus.count !== 4'd0) begin err++; $display("FAIL under_pop got v=%b c=%0d exp 0 0", bus.data_valid, bus.count); end
        chk++; if (bus.underflow_err !== ERR_EN) begin err++; $display("FAIL underflow_err got %b exp %b", bus.underflow_err, ERR_EN); end
    endtask

    task automatic test_simul();
        do_reset();
        step(0, 1, 0, 4'hA);
        step(0, 1, 0, 4'hB);
        step(0, 1, 0, 4'hC);
        step(0, 1, 1, 4'hD);
        chk++; if (obs_pr !== 1'b0 || obs_rw !== 1'b0) begin err++; $display("FAIL simul_ready got pr=%b rw=%b exp 0 0", obs_pr, obs_rw); end
        chk++; if (bus.count !== 4'd2 || bus.data_out !== 4'hA) begin err++; $display("FAIL simul_pop got c=%0d d=%h exp 2 a", bus.count, bus.data_out); end
        step(0, 1, 0, 4'hD);
        chk++; if (obs_pr !== 1'b1 || bus.count !== 4'd3) begin err++; $display("FAIL simul_push got pr=%b c=%0d exp 1 3", obs_pr, bus.count); end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0);
            chk++; if (bus.data_out !== 4'(11 + i)) begin err++; $display("FAIL simul_order got %h exp %h", bus.data_out, 4'(11 + i)); end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] v;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            v = 4'($urandom);
            step(0, 1, 0, v);
            step(0, 0, 1, 0);
            chk++; if (bus.data_valid !== 1'b1 || bus.data_out !== v) begin err++; $display("FAIL wrap_data[%0d] got v=%b d=%h exp 1 %h", i, bus.data_valid, bus.data_out, v); end
        end
    endtask

    task automatic test_thresholds();
        bus.almost_full_th = 4'd6;
        bus.almost_empty_th = 4'd1;
        do_reset();
        step(0, 0, 1, 0);
        chk++; if (bus.underflow_err !== ERR_EN) begin err++; $display("FAIL th_udf got %b exp %b", bus.underflow_err, ERR_EN); end
        for (int n = 1; n <= 6; n++) begin
            step(0, 1, 0, 4'(n));
            chk++; if (bus.almost_full !== (n >= 6) || bus.almost_empty !== (n <= 1)) begin err++; $display("FAIL th_flags[%0d] got af=%b ae=%b exp %b %b", n, bus.almost_full, bus.almost_empty, n >= 6, n <= 1); end
        end
        step(0, 0, 1, 0);
        chk++; if (bus.count !== 4'd5 || bus.almost_full !== 1'b0) begin err++; $display("FAIL th_five got c=%0d af=%b exp 5 0", bus.count, bus.almost_full); end
        step(1, 0, 0, 0);
        chk++; if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin err++; $display("FAIL th_reset got c=%0d e=%b exp 0 1", bus.count, bus.empty); end
        chk++; if (bus.overflow_err !== 1'b0 || bus.underflow_err !== 1'b0) begin err++; $display("FAIL th_errclr got %b%b exp 00", bus.overflow_err, bus.underflow_err); end
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        chk++; if (bus.data_valid !== 1'b0) begin err++; $display("FAIL th_discard got v=%b exp 0", bus.data_valid); end
    endtask

    task automatic test_random();
        bit ps, pp, rs;
        int n;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                bus.almost_full_th = 4'($urandom_range(0, 8));
                bus.almost_empty_th = 4'($urandom_range(0, 8));
            end
            ps = ($urandom_range(0, 9) < 6);
            pp = ($urandom_range(0, 9) < 5);
            rs = ($urandom_range(0, 99) == 0);
            step(rs, ps, pp, 4'($urandom));
            n = q.size();
            chk++; if (bus.count !== 4'(n) || bus.full !== (n == 8) || bus.empty !== (n == 0)) begin err++; $display("FAIL rnd_count[%0d] got c=%0d f=%b e=%b exp %0d", i, bus.count, bus.full, bus.empty, n); end
            chk++; if (bus.data_valid !== m_dv || bus.data_out !== m_dout) begin err++; $display("FAIL rnd_data[%0d] got v=%b d=%h exp %b %h", i, bus.data_valid, bus.data_out, m_dv, m_dout); end
            chk++; if (bus.almost_full !== (n >= int'(bus.almost_full_th)) || bus.almost_empty !== (n <= int'(bus.almost_empty_th))) begin err++; $display("FAIL rnd_almost[%0d] got af=%b ae=%b", i, bus.almost_full, bus.almost_empty); end
            chk++; if (obs_pr !== exp_pr || obs_rw !== exp_rw || obs_rrn !== exp_rrn) begin err++; $display("FAIL rnd_comb[%0d] got pr=%b rw=%b rrn=%b exp %b %b %b", i, obs_pr, obs_rw, obs_rrn, exp_pr, exp_rw, exp_rrn); end
            chk++; if (bus.overflow_err !== (ERR_EN & m_ovf) || bus.underflow_err !== (ERR_EN & m_udf)) begin err++; $display("FAIL rnd_errs[%0d] got %b%b exp %b%b", i, bus.overflow_err, bus.underflow_err, ERR_EN & m_ovf, ERR_EN & m_udf); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.push = 0;
        bus.pop = 0;
        bus.data_in = 0;
        bus.almost_full_th = 4'd8;
        bus.almost_empty_th = 4'd0;
        test_reset();
        test_fill();
        test_drain();
        test_simul();
        test_wrap();
        test_thresholds();
        test_random();
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
